// File: rtl/alu_pkg.sv
// Shared opcode, state and predicate definitions for the alub16 ALU and its issue controller.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'd0;
  localparam logic [OP_W-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_NAND = 4'd6;
  localparam logic [OP_W-1:0] OP_INV  = 4'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  // Only arithmetic ops produce a meaningful overflow flag.
  function automatic logic IS_ARITH(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic IS_LEGAL(input logic [OP_W-1:0] op);
    return op <= OP_INV;
  endfunction

endpackage

// File: rtl/alu_status_reg.sv
// Z/N/V status register with load enable; V is kept only for arithmetic opcodes.
module alu_status_reg
  import alu_pkg::*;
(
  input  logic            CLK,
  input  logic            reset,
  input  logic            load,
  input  logic [OP_W-1:0] op,
  input  logic            isZero,
  input  logic            isNegative,
  input  logic            ovfl,
  output logic            statZ,
  output logic            statN,
  output logic            statV
);

  logic zQ, nQ, vQ;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      zQ <= 1'b0;
      nQ <= 1'b0;
      vQ <= 1'b0;
    end else if (load) begin
      zQ <= isZero;
      nQ <= isNegative;
      vQ <= IS_ARITH(op) & ovfl;
    end
  end

  assign statZ = zQ;
  assign statN = nQ;
  assign statV = vQ;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for alub16: registers operands, captures result/flags, presents a writeback beat.
// Optional macro TRAP_OVFL_EN turns arithmetic overflow into a trap pulse instead of a writeback.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned RW = 4
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [W-1:0]    req_a,
  input  logic [W-1:0]    req_b,
  input  logic [RW-1:0]   req_rd,
  output logic [W-1:0]    alu_A,
  output logic [W-1:0]    alu_B,
  output logic [OP_W-1:0] alu_op,
  input  logic [W-1:0]    alu_R,
  input  logic            alu_isZero,
  input  logic            alu_isNegative,
  input  logic            alu_ovfl,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [W-1:0]    wb_data,
  output logic [RW-1:0]   wb_rd,
  output logic            stat_z,
  output logic            stat_n,
  output logic            stat_v,
  output logic            illegal_op,
  output logic            trap
);

  logic [1:0]      stateQ, stateD;
  logic            readyQ;
  logic [W-1:0]    aQ, bQ, dataQ;
  logic [OP_W-1:0] opQ;
  logic [RW-1:0]   rdQ;
  logic            wbValidQ, illegalQ, trapQ;
  logic            accept, reject, capture, trapHit;

  // readyQ is registered so req_ready stays low until the first edge after reset.
  assign accept  = readyQ & req_valid & IS_LEGAL(req_op);
  assign reject  = readyQ & req_valid & ~IS_LEGAL(req_op);
  assign capture = (stateQ == ST_EXEC);

`ifdef TRAP_OVFL_EN
  assign trapHit = capture & IS_ARITH(opQ) & alu_ovfl;
`else
  assign trapHit = 1'b0;
`endif

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      ST_IDLE: if (accept) stateD = ST_EXEC;
      ST_EXEC: stateD = trapHit ? ST_IDLE : ST_WB;
      ST_WB:   if (wb_ready) stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stateQ   <= ST_IDLE;
      readyQ   <= 1'b0;
      aQ       <= '0;
      bQ       <= '0;
      opQ      <= '0;
      rdQ      <= '0;
      dataQ    <= '0;
      wbValidQ <= 1'b0;
      illegalQ <= 1'b0;
      trapQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      readyQ   <= (stateD == ST_IDLE);
      illegalQ <= reject;
      trapQ    <= trapHit;
      if (accept) begin
        aQ  <= req_a;
        bQ  <= req_b;
        opQ <= req_op;
        rdQ <= req_rd;
      end
      if (capture) begin
        dataQ    <= alu_R;
        wbValidQ <= ~trapHit;
      end else if ((stateQ == ST_WB) && wb_ready) begin
        wbValidQ <= 1'b0;
      end
    end
  end

  alu_status_reg u_status (
    .CLK        (CLK),
    .reset      (reset),
    .load       (capture),
    .op         (opQ),
    .isZero     (alu_isZero),
    .isNegative (alu_isNegative),
    .ovfl       (alu_ovfl),
    .statZ      (stat_z),
    .statN      (stat_n),
    .statV      (stat_v)
  );

  assign req_ready  = readyQ;
  assign alu_A      = aQ;
  assign alu_B      = bQ;
  assign alu_op     = opQ;
  assign wb_valid   = wbValidQ;
  assign wb_data    = dataQ;
  assign wb_rd      = rdQ;
  assign illegal_op = illegalQ;
  assign trap       = trapQ;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and transaction-level status model.
module tb_alu_issue_ctrl;

`ifdef TRAP_OVFL_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        CLK, reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op, req_rd, alu_op, wb_rd;
  logic [15:0] req_a, req_b, alu_A, alu_B, alu_R, wb_data;
  logic        alu_isZero, alu_isNegative, alu_ovfl;
  logic        wb_valid, wb_ready;
  logic        stat_z, stat_n, stat_v, illegal_op, trap;
  logic        junkOvfl;

  int checks = 0;
  int failures = 0;
  logic mZ, mN, mV;
  logic [15:0] lastA, lastB;
  logic [3:0]  lastOp;

  alu_issue_ctrl #(.W(16), .RW(4)) dut (
    .CLK            (CLK),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_rd         (req_rd),
    .alu_A          (alu_A),
    .alu_B          (alu_B),
    .alu_op         (alu_op),
    .alu_R          (alu_R),
    .alu_isZero     (alu_isZero),
    .alu_isNegative (alu_isNegative),
    .alu_ovfl       (alu_ovfl),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_data        (wb_data),
    .wb_rd          (wb_rd),
    .stat_z         (stat_z),
    .stat_n         (stat_n),
    .stat_v         (stat_v),
    .illegal_op     (illegal_op),
    .trap           (trap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] refRes(input logic [3:0] op, input logic [15:0] a, b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ~(a & b);
      4'd7: return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  // Signed overflow from plain integer arithmetic; 0 for non-arithmetic ops.
  function automatic logic refOvfl(input logic [3:0] op, input logic [15:0] a, b);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == 4'd2) s = sa + sb;
    else if (op == 4'd3) s = sa - sb;
    else return 1'b0;
    return (s > 32767) || (s < -32768);
  endfunction

  // Behavioural ALU; non-arithmetic ops drive a junk overflow bit the controller must ignore.
  always_comb begin
    alu_R    = refRes(alu_op, alu_A, alu_B);
    alu_ovfl = ((alu_op == 4'd2) || (alu_op == 4'd3)) ? refOvfl(alu_op, alu_A, alu_B) : junkOvfl;
  end
  assign alu_isZero     = (alu_R == 16'h0000);
  assign alu_isNegative = alu_R[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkStat(input string nm);
    chk(nm, {29'd0, stat_z, stat_n, stat_v}, {29'd0, mZ, mN, mV});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction from IDLE; expected result/flags are supplied by the caller.
  task automatic runOp(input logic [3:0] op, input logic [15:0] a, b, input logic [3:0] rd,
                       input int stall, input logic [15:0] eData, input logic eZ, eN, eV);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    tick();
    req_op = 4'($urandom_range(0, 7)); req_a = 16'($urandom); req_b = 16'($urandom);
    req_rd = 4'($urandom);
    wb_ready = 1'($urandom_range(0, 1));
    if (op > 4'd7) begin
      req_valid = 1'b0;
      chk("illegal_pulse", {31'd0, illegal_op}, 32'd1);
      chk("illegal_ready", {31'd0, req_ready}, 32'd1);
      chk("illegal_nowb", {31'd0, wb_valid}, 32'd0);
      chk("illegal_aluA", {16'd0, alu_A}, {16'd0, lastA});
      chk("illegal_aluop", {28'd0, alu_op}, {28'd0, lastOp});
      chkStat("illegal_stat");
      tick();
      chk("illegal_clear", {31'd0, illegal_op}, 32'd0);
      chk("illegal_nowb2", {31'd0, wb_valid}, 32'd0);
      wb_ready = 1'b0;
      return;
    end
    chk("exec_ready", {31'd0, req_ready}, 32'd0);
    chk("exec_nowb", {31'd0, wb_valid}, 32'd0);
    chk("exec_aluA", {16'd0, alu_A}, {16'd0, a});
    chk("exec_aluB", {16'd0, alu_B}, {16'd0, b});
    chk("exec_aluop", {28'd0, alu_op}, {28'd0, op});
    chkStat("exec_stat_hold");
    lastA = a; lastB = b; lastOp = op;
    tick();
    mZ = eZ; mN = eN; mV = eV;
    chkStat("cap_stat");
    if (TrapEn && eV) begin
      req_valid = 1'b0; wb_ready = 1'b0;
      chk("trap_pulse", {31'd0, trap}, 32'd1);
      chk("trap_nowb", {31'd0, wb_valid}, 32'd0);
      chk("trap_rd", {28'd0, wb_rd}, {28'd0, rd});
      chk("trap_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("trap_clear", {31'd0, trap}, 32'd0);
      chk("trap_nowb2", {31'd0, wb_valid}, 32'd0);
      return;
    end
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wb_data", {16'd0, wb_data}, {16'd0, eData});
    chk("wb_rd", {28'd0, wb_rd}, {28'd0, rd});
    chk("no_trap", {31'd0, trap}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      wb_ready = 1'b0;
      tick();
      chk("stall_valid", {31'd0, wb_valid}, 32'd1);
      chk("stall_data", {16'd0, wb_data}, {16'd0, eData});
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0; req_valid = 1'b0;
    chk("wb_done", {31'd0, wb_valid}, 32'd0);
    chk("done_ready", {31'd0, req_ready}, 32'd1);
    chk("done_aluA_hold", {16'd0, alu_A}, {16'd0, a});
    chkStat("done_stat");
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [3:0]  rd;
    int          stall;
    logic [15:0] eData;
    logic        eZ, eN, eV;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'd0, 16'hFFFF, 16'h0001, 4'd3,  5, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'd2, 16'h7FFF, 16'h0001, 4'd5,  0, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{4'd7, 16'hFFFF, 16'h1234, 4'd6,  1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'd3, 16'h8000, 16'h0001, 4'd7,  0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'd1, 16'hFFFF, 16'h0001, 4'd8,  2, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'd4, 16'hAAAA, 16'h5555, 4'd9,  0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'd5, 16'h0000, 16'h0000, 4'd10, 0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{4'd6, 16'hFFFF, 16'hFFFF, 4'd11, 3, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{4'd2, 16'hFFFF, 16'h0001, 4'd12, 0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{4'd9, 16'h1111, 16'h2222, 4'd13, 0, 16'h0000, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    wb_ready = 1'b0; junkOvfl = 1'b1;
    mZ = 0; mN = 0; mV = 0; lastA = '0; lastB = '0; lastOp = '0;
    tick(); tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_aluA", {16'd0, alu_A}, 32'd0);
    chk("rst_wbdata", {16'd0, wb_data}, 32'd0);
    chkStat("rst_stat");
    reset = 1'b0;
    #1;
    chk("rel_ready_low", {31'd0, req_ready}, 32'd0);
    tick();
    chk("rel_ready_high", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 10; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].stall,
            vecs[i].eData, vecs[i].eZ, vecs[i].eN, vecs[i].eV);

    // Reset while in EXEC: everything clears immediately, no writeback follows.
    req_valid = 1'b1; req_op = 4'd0; req_a = 16'hFFFF; req_b = 16'hFFFF; req_rd = 4'd2;
    tick();
    req_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rexec_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rexec_ready", {31'd0, req_ready}, 32'd0);
    chk("rexec_aluA", {16'd0, alu_A}, 32'd0);
    chk("rexec_stat", {29'd0, stat_z, stat_n, stat_v}, 32'd0);
    tick();
    chk("rexec_wbv2", {31'd0, wb_valid}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rexec_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rexec_rel_wbv", {31'd0, wb_valid}, 32'd0);

    // Reset while in WB with the sink stalled.
    req_valid = 1'b1; req_op = 4'd4; req_a = 16'hFFFF; req_b = 16'h0000; req_rd = 4'd4;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rwb_pre_valid", {31'd0, wb_valid}, 32'd1);
    chk("rwb_pre_statn", {31'd0, stat_n}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rwb_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rwb_data", {16'd0, wb_data}, 32'd0);
    chk("rwb_rd", {28'd0, wb_rd}, 32'd0);
    chk("rwb_stat", {29'd0, stat_z, stat_n, stat_v}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    mZ = 0; mN = 0; mV = 0; lastA = '0; lastB = '0; lastOp = '0;
    runOp(4'd1, 16'hFFFF, 16'h0001, 4'd1, 1, 16'hFFFF, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op, rd;
      logic [15:0] a, b, r;
      op = 4'($urandom_range(0, 9));
      a = 16'($urandom); b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'hFFFF;
      rd = 4'($urandom);
      junkOvfl = 1'($urandom_range(0, 1));
      r = refRes(op, a, b);
      if (op > 4'd7)
        runOp(op, a, b, rd, 0, 16'h0000, mZ, mN, mV);
      else
        runOp(op, a, b, rd, int'($urandom_range(0, 3)), r, (r == 16'h0000), r[15],
              refOvfl(op, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
